// File: rtl/team_06_pkg.sv
// Shared types and helpers for the half-duplex audio arbiter.
package team_06_pkg;

  localparam int unsigned AUD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    RX    = 2'd2,
    GUARD = 2'd3
  } duplex_state_t;

  // Bits needed to hold the larger of two tick counts, never less than one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/team_06_tick_counter.sv
// Loadable down-counter stepped by sample ticks; saturates at zero, load wins over tick.
module team_06_tick_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (tick_en && (count != '0)) begin
      count_nxt = count - W'(1);
    end
  end

  // zero is kept registered alongside count so consumers see a clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_nxt;
      zero  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/team_06_duplex_arbiter.sv
// Half-duplex TX/RX arbiter: push-to-talk priority, hang time and guard gap between directions.
module team_06_duplex_arbiter
  import team_06_pkg::*;
#(
  parameter int unsigned HANG_TICKS  = 8,
  parameter int unsigned GUARD_TICKS = 4,
  parameter int unsigned RX_THRESH   = 8,
  parameter bit          PTT_PREEMPT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             ptt_en,
  input  logic [AUD_W-1:0] mic_aud,
  input  logic [AUD_W-1:0] spk_aud,
  input  logic             mute,
  output logic [1:0]       state,
  output logic             tx_grant,
  output logic             rx_grant,
  output logic [AUD_W-1:0] aud_out,
  output logic             aud_valid
);

  localparam int unsigned CNT_W = cnt_width(HANG_TICKS, GUARD_TICKS);

  duplex_state_t    cur;
  duplex_state_t    nxt;
  logic             rx_act;
  logic             hang_load;
  logic             hang_tick;
  logic             guard_load;
  logic             guard_tick;
  logic [CNT_W-1:0] hang_count;
  logic [CNT_W-1:0] guard_count;
  logic             hang_zero;
  logic             guard_zero;
  logic [AUD_W-1:0] aud_sel;

  assign rx_act = sample_tick && (spk_aud >= AUD_W'(RX_THRESH));

  // Next-state and counter control, evaluated from the current state.
  always_comb begin
    nxt        = cur;
    hang_load  = 1'b0;
    hang_tick  = 1'b0;
    guard_load = 1'b0;
    guard_tick = 1'b0;
    case (cur)
      IDLE: begin
        if (ptt_en) begin
          nxt       = TX;
          hang_load = 1'b1;
        end else if (rx_act) begin
          nxt       = RX;
          hang_load = 1'b1;
        end
      end
      TX: begin
        if (ptt_en) begin
          hang_load = 1'b1;
        end else if (hang_zero) begin
          nxt        = GUARD;
          guard_load = 1'b1;
        end else begin
          hang_tick = sample_tick;
        end
      end
      RX: begin
        if (PTT_PREEMPT && ptt_en) begin
          nxt        = GUARD;
          guard_load = 1'b1;
        end else if (rx_act) begin
          hang_load = 1'b1;
        end else if (hang_zero) begin
          nxt        = GUARD;
          guard_load = 1'b1;
        end else begin
          hang_tick = sample_tick;
        end
      end
      GUARD: begin
        if (guard_zero) begin
          nxt = IDLE;
        end else begin
          guard_tick = sample_tick;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  team_06_tick_counter #(.W(CNT_W)) u_hang (
    .clk      (clk),
    .rst      (rst),
    .load     (hang_load),
    .load_val (CNT_W'(HANG_TICKS)),
    .tick_en  (hang_tick),
    .count    (hang_count),
    .zero     (hang_zero)
  );

  team_06_tick_counter #(.W(CNT_W)) u_guard (
    .clk      (clk),
    .rst      (rst),
    .load     (guard_load),
    .load_val (CNT_W'(GUARD_TICKS)),
    .tick_en  (guard_tick),
    .count    (guard_count),
    .zero     (guard_zero)
  );

  // Sample routing uses the pre-transition state.
  always_comb begin
    aud_sel = '0;
    if (!mute) begin
      if (cur == TX) begin
        aud_sel = mic_aud;
      end else if (cur == RX) begin
        aud_sel = spk_aud;
      end
    end
  end

  // State, grants and audio; grants decode the next state so they move with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      tx_grant  <= 1'b0;
      rx_grant  <= 1'b0;
      aud_out   <= '0;
      aud_valid <= 1'b0;
    end else begin
      cur       <= nxt;
      tx_grant  <= (nxt == TX);
      rx_grant  <= (nxt == RX);
      aud_valid <= sample_tick;
      if (sample_tick) begin
        aud_out <= aud_sel;
      end
    end
  end

  assign state = cur;

  a_hang_zero_consistent: assert property (@(posedge clk) disable iff (rst)
    hang_zero == (hang_count == '0));
  a_guard_zero_consistent: assert property (@(posedge clk) disable iff (rst)
    guard_zero == (guard_count == '0));
  a_grants_exclusive: assert property (@(posedge clk) !(tx_grant && rx_grant));

endmodule

// File: tb/tb_team_06_duplex_arbiter.sv
// Scenario bench for the duplex arbiter with an audio scoreboard; a second non-preempting copy shares stimulus.
module tb_team_06_duplex_arbiter;
  import team_06_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       ptt_en = 1'b0;
  logic [7:0] mic_aud = 8'd0;
  logic [7:0] spk_aud = 8'd0;
  logic       mute = 1'b0;

  logic [1:0] state, state_np;
  logic       tx_grant, rx_grant, tx_np, rx_np;
  logic [7:0] aud_out, aud_np;
  logic       aud_valid, av_np;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       exp_v = 1'b0;

  team_06_duplex_arbiter dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ptt_en(ptt_en),
    .mic_aud(mic_aud), .spk_aud(spk_aud), .mute(mute), .state(state),
    .tx_grant(tx_grant), .rx_grant(rx_grant), .aud_out(aud_out), .aud_valid(aud_valid)
  );

  team_06_duplex_arbiter #(.PTT_PREEMPT(1'b0)) dut_np (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ptt_en(ptt_en),
    .mic_aud(mic_aud), .spk_aud(spk_aud), .mute(mute), .state(state_np),
    .tx_grant(tx_np), .rx_grant(rx_np), .aud_out(aud_np), .aud_valid(av_np)
  );

  always #5 clk = ~clk;

  always @(posedge clk) exp_v <= sample_tick && !rst;

  // Audio scoreboard: aud_valid must follow each tick by one clock with the queued sample.
  always @(negedge clk) begin
    if (exp_v || aud_valid || av_np) begin
      n_cmp++;
      if (aud_valid !== exp_v || av_np !== exp_v) begin
        n_err++;
        $display("FAIL aud_valid: got %b/%b required %b at %0t", aud_valid, av_np, exp_v, $time);
      end
      if (aud_valid === 1'b1 && exp_v) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL aud_underflow: got aud_out=%0d with no expected sample", aud_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (aud_out !== e) begin
            n_err++;
            $display("FAIL aud_out: got %0d required %0d at %0t", aud_out, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic tick(input duplex_state_t es);
    logic [7:0] e;
    e = mute ? 8'd0 : (es == TX) ? mic_aud : (es == RX) ? spk_aud : 8'd0;
    exp_q.push_back(e);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ptt_en = 1'b0; mute = 1'b0; mic_aud = 8'd0; spk_aud = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (state !== 2'd0 || tx_grant !== 1'b0 || rx_grant !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got st=%0d tx=%b rx=%b required 0/0/0", state, tx_grant, rx_grant);
    end
    ptt_en = 1'b1; mic_aud = 8'd22;
    @(negedge clk);
    tick(TX);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || tx_grant !== 1'b0 || rx_grant !== 1'b0 || aud_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_tx: got st=%0d tx=%b rx=%b av=%b required 0/0/0/0",
                        state, tx_grant, rx_grant, aud_valid);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || tx_grant !== 1'b0 || aud_out !== 8'd0) begin
      n_err++; $display("FAIL reset_hold: got st=%0d tx=%b aud=%0d required 0/0/0", state, tx_grant, aud_out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd1 || tx_grant !== 1'b1) begin
      n_err++; $display("FAIL reset_release_tx: got st=%0d tx=%b required 1/1", state, tx_grant);
    end
  endtask

  task automatic test_tx_hang();
    do_reset();
    ptt_en = 1'b1; mic_aud = 8'd60;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tick(TX);
      repeat (3) @(negedge clk);
    end
    ptt_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      n_cmp++;
      if (state !== 2'd1 || tx_grant !== 1'b1) begin
        n_err++; $display("FAIL tx_hang_%0d: got st=%0d tx=%b required 1/1", i, state, tx_grant);
      end
      tick(TX);
    end
    n_cmp++;
    if (state !== 2'd1) begin
      n_err++; $display("FAIL tx_hang_end: got st=%0d required 1", state);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (state !== 2'd3 || tx_grant !== 1'b0 || rx_grant !== 1'b0) begin
        n_err++; $display("FAIL tx_guard_%0d: got st=%0d tx=%b rx=%b required 3/0/0", i, state, tx_grant, rx_grant);
      end
      repeat (3) @(negedge clk);
      tick(GUARD);
    end
    n_cmp++;
    if (state !== 2'd3) begin
      n_err++; $display("FAIL tx_guard_end: got st=%0d required 3", state);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || tx_grant !== 1'b0) begin
      n_err++; $display("FAIL tx_to_idle: got st=%0d tx=%b required 0/0", state, tx_grant);
    end
  endtask

  task automatic test_rx_preempt();
    do_reset();
    spk_aud = 8'd57;
    tick(IDLE);
    n_cmp++;
    if (state !== 2'd2 || rx_grant !== 1'b1 || state_np !== 2'd2) begin
      n_err++; $display("FAIL rx_enter: got st=%0d rx=%b np=%0d required 2/1/2", state, rx_grant, state_np);
    end
    repeat (3) @(negedge clk);
    tick(RX);
    ptt_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd3 || rx_grant !== 1'b0 || tx_grant !== 1'b0) begin
      n_err++; $display("FAIL rx_preempt: got st=%0d rx=%b tx=%b required 3/0/0", state, rx_grant, tx_grant);
    end
    n_cmp++;
    if (state_np !== 2'd2 || rx_np !== 1'b1) begin
      n_err++; $display("FAIL rx_no_preempt: got st=%0d rx=%b required 2/1", state_np, rx_np);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      tick(GUARD);
    end
    n_cmp++;
    if (state !== 2'd3) begin
      n_err++; $display("FAIL preempt_guard_end: got st=%0d required 3", state);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd0) begin
      n_err++; $display("FAIL preempt_idle: got st=%0d required 0", state);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 2'd1 || tx_grant !== 1'b1) begin
      n_err++; $display("FAIL preempt_tx: got st=%0d tx=%b required 1/1", state, tx_grant);
    end
    mic_aud = 8'd33; spk_aud = 8'd1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (state_np !== 2'd2) begin
        n_err++; $display("FAIL np_hold_%0d: got st=%0d required 2", i, state_np);
      end
      repeat (3) @(negedge clk);
      tick(TX);
    end
    n_cmp++;
    if (state_np !== 2'd2) begin
      n_err++; $display("FAIL np_hold_end: got st=%0d required 2", state_np);
    end
    @(negedge clk);
    n_cmp++;
    if (state_np !== 2'd3 || rx_np !== 1'b0) begin
      n_err++; $display("FAIL np_guard: got st=%0d rx=%b required 3/0", state_np, rx_np);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ptt_en = 1'b1; spk_aud = 8'd65; mic_aud = 8'd9;
    tick(IDLE);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (state !== 2'd1 || rx_grant !== 1'b0 || tx_grant !== 1'b1) begin
        n_err++; $display("FAIL simul_%0d: got st=%0d tx=%b rx=%b required 1/1/0", i, state, tx_grant, rx_grant);
      end
      @(negedge clk);
      tick(TX);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    spk_aud = 8'd7;
    for (int i = 0; i < 3; i++) begin
      tick(IDLE);
      n_cmp++;
      if (state !== 2'd0 || rx_grant !== 1'b0) begin
        n_err++; $display("FAIL thresh_below_%0d: got st=%0d rx=%b required 0/0", i, state, rx_grant);
      end
      @(negedge clk);
    end
    spk_aud = 8'd8;
    tick(IDLE);
    n_cmp++;
    if (state !== 2'd2 || rx_grant !== 1'b1) begin
      n_err++; $display("FAIL thresh_at: got st=%0d rx=%b required 2/1", state, rx_grant);
    end
    tick(RX);
    n_cmp++;
    if (aud_np !== 8'd8) begin
      n_err++; $display("FAIL thresh_np_aud: got %0d required 8", aud_np);
    end
  endtask

  task automatic test_mute();
    do_reset();
    ptt_en = 1'b1; mic_aud = 8'd65;
    @(negedge clk);
    mute = 1'b1;
    tick(TX);
    n_cmp++;
    if (aud_out !== 8'd0 || aud_valid !== 1'b1) begin
      n_err++; $display("FAIL mute_on: got aud=%0d av=%b required 0/1", aud_out, aud_valid);
    end
    repeat (2) @(negedge clk);
    mute = 1'b0;
    tick(TX);
    n_cmp++;
    if (aud_out !== 8'd65) begin
      n_err++; $display("FAIL mute_off: got aud=%0d required 65", aud_out);
    end
    @(negedge clk);
    n_cmp++;
    if (aud_out !== 8'd65 || aud_valid !== 1'b0) begin
      n_err++; $display("FAIL aud_hold: got aud=%0d av=%b required 65/0", aud_out, aud_valid);
    end
  endtask

  initial begin
    test_reset();
    test_tx_hang();
    test_rx_preempt();
    test_simultaneous();
    test_threshold();
    test_mute();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/team_06_duplex_arbiter.md
Name: team_06_duplex_arbiter

Overview:
Half-duplex channel arbiter for the walkie-talkie audio path. It decides per sample whether the shared audio output carries the mic path (transmit) or the speaker path (receive). It applies push-to-talk priority, a hang time after activity ends, and a guard interval on every direction change. It sits between the mic/speaker front ends and the effect/volume stages, and it gates the top-level FSM's tx/rx enables.

Parameters:
HANG_TICKS, 8, sample ticks the current direction is held after its activity ends
GUARD_TICKS, 4, sample ticks with both grants low between directions
RX_THRESH, 8, minimum unsigned spk_aud magnitude counted as receive activity
PTT_PREEMPT, 1, 1 = ptt_en aborts an active RX; 0 = ptt_en is ignored until RX ends

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
sample_tick  input  1  one-cycle strobe per audio sample
ptt_en  input  1  push-to-talk level, already debounced
mic_aud  input  8  mic sample, unsigned
spk_aud  input  8  incoming speaker sample, unsigned magnitude, 0 = silence
mute  input  1  level; forces aud_out to 0
state  output  2  IDLE=0, TX=1, RX=2, GUARD=3
tx_grant  output  1  high exactly while state==TX
rx_grant  output  1  high exactly while state==RX
aud_out  output  8  selected sample, registered
aud_valid  output  1  one-cycle pulse, one clock after each sample_tick

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high. While rst=1 at a clk edge, the next state is IDLE and state, tx_grant, rx_grant, aud_out, aud_valid and both counters are all 0. This holds mid-TX/RX/GUARD too. No grant is asserted in the cycle after rst is released.
- Grants: tx_grant and rx_grant are registered and decoded from the next state, so they change in the same edge as state. They are never both 1.
- rx_act = sample_tick && (spk_aud >= RX_THRESH). This is an 8-bit unsigned compare.
- IDLE:
  - ptt_en=1 -> TX, with hang_cnt loaded to HANG_TICKS.
  - Otherwise, rx_act -> RX, with hang_cnt loaded to HANG_TICKS.
  - If both occur in the same cycle, ptt_en wins.
- TX:
  - While ptt_en=1, hang_cnt reloads to HANG_TICKS every cycle.
  - While ptt_en=0, hang_cnt decrements on sample_tick and saturates at 0.
  - ptt_en=0 and hang_cnt==0 -> GUARD, with guard_cnt loaded to GUARD_TICKS. This check runs every cycle, not only on ticks.
  - Re-pressing ptt_en during the hang reloads hang_cnt and stays in TX.
- RX:
  - rx_act reloads hang_cnt.
  - A tick with spk_aud < RX_THRESH decrements it.
  - hang_cnt==0 -> GUARD.
  - If PTT_PREEMPT=1, ptt_en=1 -> GUARD immediately. This takes priority over the hang logic.
- GUARD:
  - Both grants are 0.
  - guard_cnt decrements on sample_tick.
  - guard_cnt==0 -> IDLE.
  - If GUARD_TICKS=0, GUARD lasts exactly one cycle.
  - ptt_en and rx_act are ignored during GUARD and re-evaluated in IDLE.
- HANG_TICKS=0: TX is left in the first cycle with ptt_en=0. RX is left in the cycle after entry unless rx_act reloads it.
- Audio output:
  - On each sample_tick, aud_out is registered as: mic_aud if the current state is TX, spk_aud if RX, 0 otherwise.
  - mute=1 forces the value to 0.
  - aud_valid=1 in the following cycle, so latency is 1 clock. It pulses on every tick, in any state, including while muted.
  - aud_out holds its value between ticks.
- sample_tick arriving in the same cycle as a state transition: the sample is selected using the pre-transition state. A counter load takes precedence over a decrement in that cycle.
- Counter widths: $clog2(max(HANG_TICKS, GUARD_TICKS)+1), with a minimum of 1 bit. Decrement at 0 is blocked, so there is no wrap-around.

Decomposition:
- team_06_pkg holds:
  - the typedef enum logic [1:0] duplex_state_t {IDLE, TX, RX, GUARD};
  - the localparam AUD_W=8.
- Sub-module team_06_tick_counter: a parameterised loadable down-counter with inputs load, load_val and tick_en, and outputs count and zero.
  - Instantiated twice, once for hang and once for guard.
  - Tick decrement saturates at 0; load overrides tick.

Test Plan:
- Reset: hold rst=1 for 3 cycles during TX with ptt_en=1 -> state=0, both grants=0 and aud_valid=0 on the next edge. After rst falls with ptt_en=1 held, state=1 after exactly one edge.
- TX hang: ptt_en=1 with mic_aud=60 and a tick every 4 clocks -> aud_out=60 with aud_valid one clock after each tick. Drop ptt_en -> still TX for 8 ticks, then GUARD for 4 ticks, then IDLE. tx_grant is low from GUARD entry.
- RX and preempt: spk_aud=57 on a tick in IDLE -> RX, aud_out=57. Then assert ptt_en -> GUARD next edge (PTT_PREEMPT=1), then TX after 4 ticks plus one cycle in IDLE. With PTT_PREEMPT=0, RX holds until spk_aud=1 for 8 ticks.
- Simultaneous: in IDLE, ptt_en=1 and spk_aud=65 arrive on the same tick -> TX, and rx_grant never rises.
- Threshold boundary: spk_aud=7 on ticks -> stays IDLE. spk_aud=8 -> RX.
- Mute: in TX with mic_aud=65 and mute=1 -> aud_out=0 and aud_valid still pulses. Release mute -> next tick gives aud_out=65.
